// File: rtl/branch_unit_pipe.sv
// Branch resolution: compare, target/fall-through select, mispredict flag, saturating stats.
// Latency 2 cycles (S1 compare/add, S2 select); one result per cycle when i_ready stays high.
// Holds 2 requests under back-pressure; o_ready drops combinationally, no skid buffer.
module branch_unit_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_b,
  input  logic [2:0]       i_cmp_op,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic             i_pred_taken,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_taken,
  output logic [XLEN-1:0]  o_target,
  output logic             o_mispredict,
  output logic [CNT_W-1:0] o_branches,
  output logic [CNT_W-1:0] o_mispredicts
);

  localparam logic [2:0] OP_EQ   = 3'b000;
  localparam logic [2:0] OP_NE   = 3'b001;
  localparam logic [2:0] OP_ALW  = 3'b010;
  localparam logic [2:0] OP_NEV  = 3'b011;
  localparam logic [2:0] OP_LT   = 3'b100;
  localparam logic [2:0] OP_GE   = 3'b101;
  localparam logic [2:0] OP_LTU  = 3'b110;
  localparam logic [2:0] OP_GEU  = 3'b111;

  // Stage 1: compare result plus both candidate next PCs.
  logic             s1_valid_q;
  logic             s1_taken_q;
  logic             s1_pred_q;
  logic [XLEN-1:0]  s1_tgt_q;
  logic [XLEN-1:0]  s1_seq_q;

  // Stage 2: the architecturally visible result registers.
  logic             s2_valid_q;
  logic             s2_taken_q;
  logic             s2_misp_q;
  logic [XLEN-1:0]  s2_target_q;

  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic             cmp_taken;
  logic             s2_load;
  logic             accept;
  logic             xfer;

  // S2 can take a new value when empty or when its current result leaves this cycle.
  assign s2_load = !s2_valid_q || i_ready;
  // S1 is free when empty or when it moves into S2; flush blocks new input.
  assign o_ready = !i_flush && (!s1_valid_q || s2_load);
  assign accept  = i_valid && o_ready;
  // A handshake in the flush cycle still counts as delivered.
  assign xfer    = s2_valid_q && i_ready;

  assign o_valid       = s2_valid_q;
  assign o_taken       = s2_taken_q;
  assign o_target      = s2_target_q;
  assign o_mispredict  = s2_misp_q;
  assign o_branches    = br_cnt_q;
  assign o_mispredicts = mp_cnt_q;

  // Evaluate the requested compare on the incoming operands.
  always_comb begin
    cmp_taken = 1'b0;
    case (i_cmp_op)
      OP_EQ:   cmp_taken = (i_a == i_b);
      OP_NE:   cmp_taken = (i_a != i_b);
      OP_ALW:  cmp_taken = 1'b1;
      OP_NEV:  cmp_taken = 1'b0;
      OP_LT:   cmp_taken = ($signed(i_a) <  $signed(i_b));
      OP_GE:   cmp_taken = ($signed(i_a) >= $signed(i_b));
      OP_LTU:  cmp_taken = (i_a <  i_b);
      OP_GEU:  cmp_taken = (i_a >= i_b);
      default: cmp_taken = 1'b0;
    endcase
  end

  // Saturating statistics: bump on each delivered result, stick at all-ones.
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (xfer && (br_cnt_q != {CNT_W{1'b1}})) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (xfer && s2_misp_q && (mp_cnt_q != {CNT_W{1'b1}})) begin
      mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline advance, flush and reset; reset overrides flush and every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_taken_q  <= 1'b0;
      s1_pred_q   <= 1'b0;
      s1_tgt_q    <= '0;
      s1_seq_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_taken_q  <= 1'b0;
      s2_misp_q   <= 1'b0;
      s2_target_q <= '0;
    end else if (i_flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_taken_q  <= s1_taken_q;
          s2_target_q <= s1_taken_q ? s1_tgt_q : s1_seq_q;
          s2_misp_q   <= s1_taken_q ^ s1_pred_q;
        end
      end
      if (o_ready) begin
        s1_valid_q <= i_valid;
        if (accept) begin
          s1_taken_q <= cmp_taken;
          s1_pred_q  <= i_pred_taken;
          s1_tgt_q   <= i_pc + i_imm;
          s1_seq_q   <= i_pc + XLEN'(4);
        end
      end
    end
  end

  // Statistics counters; survive flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_unit_pipe.sv
module tb_branch_unit_pipe;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_a, i_b, i_pc, i_imm;
  logic [2:0]  i_cmp_op;
  logic        i_pred_taken;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic        o_taken;
  logic [31:0] o_target;
  logic        o_mispredict;
  logic [15:0] o_branches, o_mispredicts;

  logic        sat_o_ready, sat_o_valid, sat_o_taken, sat_o_mispredict;
  logic [31:0] sat_o_target;
  logic [1:0]  sat_o_branches, sat_o_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_unit_pipe #(.XLEN(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_cmp_op(i_cmp_op), .i_pc(i_pc), .i_imm(i_imm),
    .i_pred_taken(i_pred_taken), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_taken(o_taken), .o_target(o_target),
    .o_mispredict(o_mispredict), .o_branches(o_branches),
    .o_mispredicts(o_mispredicts)
  );

  branch_unit_pipe #(.XLEN(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(sat_o_ready),
    .i_a(i_a), .i_b(i_b), .i_cmp_op(i_cmp_op), .i_pc(i_pc), .i_imm(i_imm),
    .i_pred_taken(i_pred_taken), .i_flush(i_flush), .o_valid(sat_o_valid),
    .i_ready(i_ready), .o_taken(sat_o_taken), .o_target(sat_o_target),
    .o_mispredict(sat_o_mispredict), .o_branches(sat_o_branches),
    .o_mispredicts(sat_o_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred);
    i_valid = v; i_cmp_op = op; i_a = a; i_b = b;
    i_pc = pc; i_imm = imm; i_pred_taken = pred;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h req 0", o_valid); end
    checks++; if (o_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %0h req 0", o_taken); end
    checks++; if (o_target !== 32'h0) begin errors++; $display("FAIL reset_target got %h req 0", o_target); end
    checks++; if (o_mispredict !== 1'b0) begin errors++; $display("FAIL reset_misp got %0h req 0", o_mispredict); end
    checks++; if (o_branches !== 16'd0 || o_mispredicts !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d req 0/0", o_branches, o_mispredicts); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h req 1", o_ready); end
  endtask

  task automatic test_compare_sweep();
    logic [7:0] exp_taken;
    exp_taken = 8'h56;  // bit k = expected taken for op k with a=10, b=15
    do_reset();
    i_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) drive(1'b1, 3'(k), 32'd10, 32'd15, 32'h100, 32'h20, 1'b0);
      else       i_valid = 1'b0;
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready k=%0d got %0h req 1", k, o_ready); end
      step();
      if (k == 0) begin
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL sweep_latency got valid %0h req 0", o_valid); end
      end else begin
        checks++;
        if (o_valid !== 1'b1 || o_taken !== exp_taken[k-1] ||
            o_target !== (exp_taken[k-1] ? 32'h120 : 32'h104)) begin
          errors++;
          $display("FAIL sweep_op%0d got v=%0h t=%0h tgt=%h req v=1 t=%0h tgt=%h", k-1, o_valid,
                   o_taken, o_target, exp_taken[k-1], exp_taken[k-1] ? 32'h120 : 32'h104);
        end
      end
    end
    step();
    checks++; if (o_valid !== 1'b0 || o_branches !== 16'd8 || o_mispredicts !== 16'd4) begin
      errors++; $display("FAIL sweep_cnt got v=%0h br=%0d mp=%0d req v=0 br=8 mp=4", o_valid, o_branches, o_mispredicts); end
  endtask

  task automatic test_signedness();
    logic [2:0]  ops  [6] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b011, 3'b010};
    logic [31:0] pcs  [6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'hFFFFFFFC, 32'hFFFFFFFC};
    logic [31:0] imms [6] = '{32'hFFFFFFF8, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'h8};
    logic        etk  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] etg  [6] = '{32'hF8, 32'h104, 32'h104, 32'hF8, 32'h0, 32'h4};
    do_reset();
    i_ready = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) drive(1'b1, ops[k], 32'hFFFFFFFF, 32'd1, pcs[k], imms[k], 1'b0);
      else       i_valid = 1'b0;
      step();
      if (k > 0) begin
        checks++;
        if (o_valid !== 1'b1 || o_taken !== etk[k-1] || o_target !== etg[k-1]) begin
          errors++;
          $display("FAIL sign_vec%0d got v=%0h t=%0h tgt=%h req v=1 t=%0h tgt=%h", k-1, o_valid,
                   o_taken, o_target, etk[k-1], etg[k-1]);
        end
      end
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    i_ready = 1'b1;
    drive(1'b1, 3'b100, 32'd10, 32'd15, 32'h200, 32'h40, 1'b0);
    step();
    i_pred_taken = 1'b1;
    step();
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b1 || o_mispredict !== 1'b1 || o_target !== 32'h240) begin
      errors++; $display("FAIL misp_pred0 got v=%0h m=%0h tgt=%h req v=1 m=1 tgt=00000240", o_valid, o_mispredict, o_target); end
    step();
    checks++; if (o_valid !== 1'b1 || o_mispredict !== 1'b0) begin
      errors++; $display("FAIL misp_pred1 got v=%0h m=%0h req v=1 m=0", o_valid, o_mispredict); end
    step();
    checks++; if (o_branches !== 16'd2 || o_mispredicts !== 16'd1) begin
      errors++; $display("FAIL misp_cnt got br=%0d mp=%0d req br=2 mp=1", o_branches, o_mispredicts); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    i_ready = 1'b0;
    drive(1'b1, 3'b010, 32'd0, 32'd0, 32'h100, 32'h10, 1'b1);
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a got %0h req 1", o_ready); end
    step();
    i_imm = 32'h20;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b got %0h req 1", o_ready); end
    step();
    i_imm = 32'h30;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c got %0h req 0", o_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (o_valid !== 1'b1 || o_target !== 32'h110 || o_taken !== 1'b1 || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%0h tgt=%h t=%0h rdy=%0h req v=1 tgt=00000110 t=1 rdy=0",
                 k, o_valid, o_target, o_taken, o_ready);
      end
    end
    i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1 || o_target !== 32'h110) begin
      errors++; $display("FAIL bp_release got rdy=%0h tgt=%h req rdy=1 tgt=00000110", o_ready, o_target); end
    step();
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b1 || o_target !== 32'h120) begin
      errors++; $display("FAIL bp_second got v=%0h tgt=%h req v=1 tgt=00000120", o_valid, o_target); end
    step();
    checks++; if (o_valid !== 1'b1 || o_target !== 32'h130) begin
      errors++; $display("FAIL bp_third got v=%0h tgt=%h req v=1 tgt=00000130", o_valid, o_target); end
    step();
    checks++; if (o_valid !== 1'b0 || o_branches !== 16'd3) begin
      errors++; $display("FAIL bp_done got v=%0h br=%0d req v=0 br=3", o_valid, o_branches); end
  endtask

  task automatic test_flush();
    // Two held in flight, flush kills them and the input offered alongside.
    do_reset();
    i_ready = 1'b0;
    drive(1'b1, 3'b010, 32'd0, 32'd0, 32'h100, 32'h10, 1'b1);
    step();
    i_imm = 32'h20;
    step();
    i_imm = 32'h30;
    i_flush = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0h req 0", o_ready); end
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h req 0", o_valid); end
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_drop%0d got v=%0h req 0", k, o_valid); end
    end
    checks++; if (o_branches !== 16'd0) begin errors++; $display("FAIL flush_cnt0 got %0d req 0", o_branches); end
    // A transfer completing in the flush cycle is still counted.
    do_reset();
    i_ready = 1'b1;
    drive(1'b1, 3'b010, 32'd0, 32'd0, 32'h100, 32'h10, 1'b1);
    step();
    i_imm = 32'h20;
    step();
    i_valid = 1'b0;
    i_flush = 1'b1;
    checks++; if (o_valid !== 1'b1 || o_target !== 32'h110) begin
      errors++; $display("FAIL flushx_pre got v=%0h tgt=%h req v=1 tgt=00000110", o_valid, o_target); end
    step();
    i_flush = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_branches !== 16'd1) begin
      errors++; $display("FAIL flushx_post got v=%0h br=%0d req v=0 br=1", o_valid, o_branches); end
    step();
    checks++; if (o_valid !== 1'b0 || o_branches !== 16'd1) begin
      errors++; $display("FAIL flushx_kill got v=%0h br=%0d req v=0 br=1", o_valid, o_branches); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    i_ready = 1'b1;
    drive(1'b1, 3'b010, 32'd0, 32'd0, 32'h100, 32'h40, 1'b0);
    step(); step(); step();
    i_ready = 1'b0;
    step(); step();
    checks++; if (o_valid !== 1'b1 || o_mispredict !== 1'b1 || o_branches !== 16'd1 || o_mispredicts !== 16'd1) begin
      errors++; $display("FAIL rstmid_pre got v=%0h m=%0h br=%0d mp=%0d req v=1 m=1 br=1 mp=1",
                         o_valid, o_mispredict, o_branches, o_mispredicts); end
    rst = 1'b1; i_flush = 1'b1; i_ready = 1'b1;
    step();
    checks++;
    if (o_valid !== 1'b0 || o_taken !== 1'b0 || o_target !== 32'h0 || o_mispredict !== 1'b0 ||
        o_branches !== 16'd0 || o_mispredicts !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_clear got v=%0h t=%0h tgt=%h m=%0h br=%0d mp=%0d req all 0", o_valid,
               o_taken, o_target, o_mispredict, o_branches, o_mispredicts);
    end
    rst = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0h req 1", o_ready); end
  endtask

  task automatic test_saturation();
    do_reset();
    i_ready = 1'b1;
    drive(1'b1, 3'b010, 32'd0, 32'd0, 32'h100, 32'h8, 1'b0);
    repeat (5) step();
    i_valid = 1'b0;
    step(); step();
    checks++; if (sat_o_branches !== 2'd3 || sat_o_mispredicts !== 2'd3) begin
      errors++; $display("FAIL sat_cnt got br=%0d mp=%0d req br=3 mp=3", sat_o_branches, sat_o_mispredicts); end
    checks++; if (o_branches !== 16'd5 || o_mispredicts !== 16'd5) begin
      errors++; $display("FAIL sat_wide got br=%0d mp=%0d req br=5 mp=5", o_branches, o_mispredicts); end
    step(); step();
    checks++; if (sat_o_branches !== 2'd3 || sat_o_mispredicts !== 2'd3 || sat_o_valid !== 1'b0) begin
      errors++; $display("FAIL sat_hold got br=%0d mp=%0d v=%0h req br=3 mp=3 v=0", sat_o_branches,
                         sat_o_mispredicts, sat_o_valid); end
  endtask

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    test_reset();
    test_compare_sweep();
    test_signedness();
    test_mispredict();
    test_back_pressure();
    test_flush();
    test_reset_midstream();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
